// File: rtl/addr_seq5.sv
// addr_seq5: sequential select-code generator for a 5-to-32 one-hot decoder.
//
// Walks the captured range first..last (modulo 32, so first>last wraps through
// 31->0). Each code is offered on sel under a sel_valid/sel_ready handshake.
// An optional dwell gap of DWELL idle cycles precedes each new code.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      begin a scan (sampled only in IDLE)
//   abort      cancel a scan in progress (beats start and same-cycle accept)
//   first/last range bounds, captured when start is accepted
//   sel        current select code to the decoder
//   sel_valid  sel may be consumed
//   sel_ready  consumer accepts sel this cycle
//   busy       scan in progress (GAP or RUN)
//   done       one-cycle pulse after the last code is accepted
//
// Optional feature: define ADDR_SEQ5_AUTO_RELOAD_EN to make the scan loop
// forever (done pulses on every pass, sel reloads first); DONE is then unused.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start
//   GAP    | dwell countdown before presenting sel
//   RUN    | sel_valid high, waiting for accept
//   DONE   | done pulse, back to IDLE next cycle

module addr_seq5 #(
  parameter int ADDR_W = 5,
  parameter int DWELL  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] sel,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_RUN, S_DONE} state_t;

  localparam logic [7:0]        DWELL_C = 8'(DWELL);
  localparam logic [ADDR_W-1:0] SEL_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      first_q <= first_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    first_d = first_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          first_d = first;
          last_d  = last;
          sel_d   = first;
          if (DWELL == 0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_GAP;
            cnt_d   = DWELL_C;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          // Terminal count at 1 so GAP lasts exactly DWELL cycles.
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sel_ready) begin
          if (sel_q == last_q) begin
            done_d = 1'b1;
`ifdef ADDR_SEQ5_AUTO_RELOAD_EN
            sel_d = first_q;
            if (DWELL != 0) begin
              state_d = S_GAP;
              cnt_d   = DWELL_C;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
            sel_d = sel_q + SEL_ONE;
            if (DWELL != 0) begin
              state_d = S_GAP;
              cnt_d   = DWELL_C;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    sel       = sel_q;
    sel_valid = (state_q == S_RUN);
    busy      = (state_q == S_RUN) || (state_q == S_GAP);
    done      = done_q;
  end

endmodule

// File: tb/tb_addr_seq5.sv
module tb_addr_seq5;

  logic       clk = 1'b0;
  logic       rst, start, abort, sel_ready;
  logic [4:0] first, last;
  logic [4:0] sel0, sel2;
  logic       valid0, valid2, busy0, busy2, done0, done2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addr_seq5 #(.ADDR_W(5), .DWELL(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first(first), .last(last), .sel(sel0), .sel_valid(valid0),
    .sel_ready(sel_ready), .busy(busy0), .done(done0)
  );

  addr_seq5 #(.ADDR_W(5), .DWELL(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .first(first), .last(last), .sel(sel2), .sel_valid(valid2),
    .sel_ready(sel_ready), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] exp_sel;
    int         accepted;

    rst = 1'b1; start = 1'b0; abort = 1'b0; sel_ready = 1'b0;
    first = 5'd0; last = 5'd0;
    step(); step();
    rst = 1'b0;

    // Idle after reset: {sel,sel_valid,busy,done} all zero
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_idle", {sel0, valid0, busy0, done0}, 32'h0);
    end

`ifdef ADDR_SEQ5_AUTO_RELOAD_EN
    // Range 0..2 loops forever; done follows each accept of 2
    first = 5'd0; last = 5'd2; sel_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("ar_sel", sel0, i % 3);
      check("ar_busy", {valid0, busy0}, 2'b11);
      check("ar_done", done0, (i > 0 && i % 3 == 0) ? 1 : 0);
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ar_abort", {valid0, busy0, done0}, 3'b000);
`else
    // DWELL=0, 3..6, ready held high
    first = 5'd3; last = 5'd6; sel_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("lin_sel", sel0, 3 + i);
      check("lin_vbd", {valid0, busy0, done0}, 3'b110);
      step();
    end
    check("lin_done", {sel0, valid0, busy0, done0}, {5'd6, 3'b001});
    step();
    check("lin_idle", {valid0, busy0, done0}, 3'b000);

    // Wrap 30..1 with ready toggling
    first = 5'd30; last = 5'd1; sel_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp_sel = 5'd30;
    accepted = 0;
    for (int c = 0; c < 12 && accepted < 4; c++) begin
      sel_ready = (c % 2 == 0);
      check("wrap_sel", sel0, exp_sel);
      check("wrap_vbd", {valid0, busy0, done0}, 3'b110);
      step();
      if (c % 2 == 0) begin
        exp_sel = exp_sel + 5'd1;
        accepted++;
      end
    end
    check("wrap_cnt", accepted, 4);
    check("wrap_done", {sel0, valid0, busy0, done0}, {5'd1, 3'b001});
    step();
    check("wrap_done_once", done0, 1'b0);

    // DWELL=2 instance, single address 9
    do_reset();
    first = 5'd9; last = 5'd9; sel_ready = 1'b1; start = 1'b1;
    step();
    check("dw_gap1", {valid2, busy2}, 2'b01);
    step();                       // start still high during GAP: ignored
    check("dw_gap2", {valid2, busy2}, 2'b01);
    step();
    check("dw_run", {sel2, valid2, busy2, done2}, {5'd9, 3'b110});
    step();                       // start still high in RUN: ignored
    check("dw_done", {sel2, valid2, busy2, done2}, {5'd9, 3'b001});
    start = 1'b0;
    step();
    check("dw_idle", {valid2, busy2, done2}, 3'b000);
    step();
    check("dw_stay_idle", {valid2, busy2, done2}, 3'b000);

    // Abort together with accept of 12 in range 10..20
    do_reset();
    first = 5'd10; last = 5'd20; sel_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("ab_pre", sel0, 5'd12);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_post", {sel0, valid0, busy0, done0}, {5'd12, 3'b000});
    step();
    check("ab_no_done", done0, 1'b0);

    // Restart from new first; inputs change after capture
    first = 5'd15; last = 5'd16; start = 1'b1;
    step();
    start = 1'b0; first = 5'd0; last = 5'd0;
    check("rs_first", {sel0, valid0}, {5'd15, 1'b1});
    step();
    check("rs_next", sel0, 5'd16);
    step();
    check("rs_done", {sel0, valid0, busy0, done0}, {5'd16, 3'b001});
    step();

    // start+abort together in IDLE: nothing happens
    first = 5'd4; last = 5'd7; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("sa_idle", {valid0, busy0}, 2'b00);

    // Reset mid-scan
    sel_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("rst_pre", {sel0, valid0}, {5'd4, 1'b1});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid", {sel0, valid0, busy0, done0}, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
